// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared types, lane masks and helpers for the data memory controller
package data_mem_ctrl_pkg;

  // CPU access width encoding; the unused code 2'd3 behaves as DWORD
  typedef enum logic [1:0] {
    W_BYTE  = 2'd0,
    W_WORD  = 2'd1,
    W_DWORD = 2'd2
  } width_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR,
    ERR,
    RD_HI,
    WR_HI
  } ctrl_state_t;

  localparam logic [3:0] BYTE_MASK  = 4'b0001;
  localparam logic [3:0] WORD_MASK  = 4'b0011;
  localparam logic [3:0] DWORD_MASK = 4'b1111;

  // Unshifted byte-lane mask for an access width
  function automatic logic [3:0] lane_mask(input logic [1:0] width);
    case (width)
      W_BYTE:  lane_mask = BYTE_MASK;
      W_WORD:  lane_mask = WORD_MASK;
      default: lane_mask = DWORD_MASK;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lanes.sv
// rtl/data_mem_ctrl_lanes.sv - width/offset to byte enables, store shift, load extract and merge
module data_mem_lanes
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_lo,
  input  logic [31:0] load_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] din_lo,
  output logic [31:0] din_hi,
  output logic [31:0] load_data,
  output logic        crosses
);

  logic [3:0]  lanes;
  logic [7:0]  be_wide;
  logic [63:0] din_wide;
  logic [31:0] data_mask;

  // Work on a two-word window so boundary-crossing accesses fall out of the same shift
  always_comb begin
    lanes     = lane_mask(width);
    be_wide   = {4'b0000, lanes} << offset;
    din_wide  = {32'd0, store_data} << {offset, 3'b000};
    data_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    be_lo     = be_wide[3:0];
    be_hi     = be_wide[7:4];
    din_lo    = din_wide[31:0];
    din_hi    = din_wide[63:32];
    load_data = 32'({load_hi, load_lo} >> {offset, 3'b000}) & data_mask;
    crosses   = |be_wide[7:4];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data-bus slave driving a byte-enabled BRAM; DATA_MEM_SPLIT_EN enables word-crossing accesses
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int  DEPTH        = 4096,
  parameter int  READ_LATENCY = 2,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              dispatch_read,
  input  logic              dispatch_write,
  input  logic [31:0]       addr,
  input  logic [1:0]        mem_width,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              busy,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  ctrl_state_t       state_q, state_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [3:0]        bram_we_q, bram_we_d;
  logic [31:0]       bram_din_q, bram_din_d;
  logic              misalign_err_q, misalign_err_d;
  logic [1:0]        off_q, off_d, width_q, width_d;

  logic        idle, req_rd, req_wr, out_of_range, reject, crosses;
  logic [1:0]  ln_width, ln_off;
  logic [3:0]  be_lo, be_hi;
  logic [31:0] din_lo, din_hi, ld_lo, ld_hi, load_data;

`ifdef DATA_MEM_SPLIT_EN
  logic        split_q, split_d, hi_q, hi_d;
  logic [31:0] lo_q, lo_d, hi_din_q, hi_din_d;
  logic [3:0]  hi_we_q, hi_we_d;
`else
  logic aligned;
  logic unused_hi;
`endif

  assign idle         = (state_q == IDLE);
  assign req_wr       = dispatch_write;
  assign req_rd       = dispatch_read & ~dispatch_write;
  assign busy         = dispatch_read | dispatch_write | ~idle;
  assign ln_width     = idle ? mem_width : width_q;
  assign ln_off       = idle ? addr[1:0] : off_q;
  assign out_of_range = addr[31:2] >= 30'(DEPTH);

`ifdef DATA_MEM_SPLIT_EN
  assign ld_lo  = split_q ? lo_q : bram_dout;
  assign ld_hi  = split_q ? bram_dout : 32'd0;
  assign reject = out_of_range | (crosses & (addr[31:2] >= 30'(DEPTH - 1)));
`else
  // Natural alignment: halfwords on even bytes, words on word boundaries
  always_comb begin
    case (mem_width)
      W_BYTE:  aligned = 1'b1;
      W_WORD:  aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end
  assign ld_lo     = bram_dout;
  assign ld_hi     = 32'd0;
  assign reject    = out_of_range | ~aligned;
  assign unused_hi = ^{be_hi, din_hi, crosses};
`endif

  data_mem_lanes u_lanes (
    .width      (ln_width),
    .offset     (ln_off),
    .store_data (write_data),
    .load_lo    (ld_lo),
    .load_hi    (ld_hi),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .din_lo     (din_lo),
    .din_hi     (din_hi),
    .load_data  (load_data),
    .crosses    (crosses)
  );

  // Next-state and registered-output logic; write enables and the error flag are single-cycle pulses
  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    read_data_d    = read_data_q;
    bram_addr_d    = bram_addr_q;
    bram_we_d      = 4'b0000;
    bram_din_d     = bram_din_q;
    misalign_err_d = 1'b0;
    off_d          = off_q;
    width_d        = width_q;
`ifdef DATA_MEM_SPLIT_EN
    split_d        = split_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    hi_din_d       = hi_din_q;
    hi_we_d        = hi_we_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_wr || req_rd) begin
          off_d   = addr[1:0];
          width_d = mem_width;
          if (reject) begin
            state_d        = ERR;
            misalign_err_d = 1'b1;
            if (req_rd) read_data_d = 32'd0;
          end else begin
            bram_addr_d = addr[ADDR_W+1:2];
`ifdef DATA_MEM_SPLIT_EN
            split_d  = crosses;
            hi_d     = 1'b0;
            hi_we_d  = be_hi;
            hi_din_d = din_hi;
`endif
            if (req_wr) begin
              state_d    = WR;
              bram_we_d  = be_lo;
              bram_din_d = din_lo;
            end else begin
              state_d   = RD_WAIT;
              lat_cnt_d = 3'd0;
            end
          end
        end
      end
      RD_WAIT, RD_HI: begin
        if (lat_cnt_q == LAT_LAST) state_d = RD_CAP;
        else lat_cnt_d = lat_cnt_q + 3'd1;
      end
      RD_CAP: begin
`ifdef DATA_MEM_SPLIT_EN
        if (split_q && !hi_q) begin
          lo_d        = bram_dout;
          hi_d        = 1'b1;
          bram_addr_d = bram_addr_q + ADDR_W'(1);
          lat_cnt_d   = 3'd0;
          state_d     = RD_HI;
        end else begin
          read_data_d = load_data;
          state_d     = IDLE;
        end
`else
        read_data_d = load_data;
        state_d     = IDLE;
`endif
      end
      WR: begin
`ifdef DATA_MEM_SPLIT_EN
        if (split_q) begin
          bram_we_d   = hi_we_q;
          bram_din_d  = hi_din_q;
          bram_addr_d = bram_addr_q + ADDR_W'(1);
          state_d     = WR_HI;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      ERR, WR_HI: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      lat_cnt_q      <= 3'd0;
      read_data_q    <= 32'd0;
      bram_addr_q    <= '0;
      bram_we_q      <= 4'b0000;
      bram_din_q     <= 32'd0;
      misalign_err_q <= 1'b0;
      off_q          <= 2'd0;
      width_q        <= 2'd0;
`ifdef DATA_MEM_SPLIT_EN
      split_q        <= 1'b0;
      hi_q           <= 1'b0;
      lo_q           <= 32'd0;
      hi_din_q       <= 32'd0;
      hi_we_q        <= 4'b0000;
`endif
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      read_data_q    <= read_data_d;
      bram_addr_q    <= bram_addr_d;
      bram_we_q      <= bram_we_d;
      bram_din_q     <= bram_din_d;
      misalign_err_q <= misalign_err_d;
      off_q          <= off_d;
      width_q        <= width_d;
`ifdef DATA_MEM_SPLIT_EN
      split_q        <= split_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      hi_din_q       <= hi_din_d;
      hi_we_q        <= hi_we_d;
`endif
    end
  end

  assign read_data    = read_data_q;
  assign bram_addr    = bram_addr_q;
  assign bram_we      = bram_we_q;
  assign bram_din     = bram_din_q;
  assign misalign_err = misalign_err_q;

endmodule
